// File: rtl/bounce_if.sv
// Bounce generator bus: the requested clean level going in, the bouncy
// emulated switch output and the burst-in-progress flag coming out.
interface bounce_if;
    logic btn_in;
    logic sw_out;
    logic busy;

    modport master (output btn_in, input sw_out, input busy);
    modport slave  (input btn_in, output sw_out, output busy);
endinterface

// File: rtl/bounce_gen.sv
// Mechanical switch emulator: every change of the requested level produces
// one immediate edge followed by 2*N_BOUNCES pseudo-randomly spaced toggles
// before the output settles on the new level.
module bounce_gen #(
    parameter int N_BOUNCES = 6,
    parameter int GAP_BITS  = 8
) (
    input  logic     clk,
    input  logic     rst,
    bounce_if.slave  bus
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] BOUNCE = 1'b1;

    // Toggle counter must hold 2*N_BOUNCES; keep at least one bit when N_BOUNCES is 0.
    localparam int TW = (N_BOUNCES == 0) ? 1 : $clog2(2 * N_BOUNCES + 1);

    localparam logic [TW-1:0]     T_LOAD    = TW'(2 * N_BOUNCES);
    localparam logic [TW-1:0]     T_ONE     = TW'(1);
    localparam logic [GAP_BITS:0] GAP_ONE   = (GAP_BITS + 1)'(1);
    localparam logic [15:0]       LFSR_SEED = 16'hACE1;

    logic [0:0]        state;
    logic              level;
    logic              target;
    logic              sw_q;
    logic [GAP_BITS:0] gap_cnt;
    logic [TW-1:0]     tog_cnt;
    logic [15:0]       lfsr;
    logic              lfsr_fb;
    logic [GAP_BITS:0] next_gap;

    // Taps 16,14,13,11 in right-shift Fibonacci form; a non-zero seed never reaches 0.
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    // Gap is one extra bit wide so the all-ones random value plus one cannot wrap.
    assign next_gap = {1'b0, lfsr[GAP_BITS-1:0]} + GAP_ONE;

    // Free-running random source, advancing every cycle regardless of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end

    // Burst control: start a burst on a level change, toggle when the gap expires, settle on target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            level   <= 1'b0;
            target  <= 1'b0;
            sw_q    <= 1'b0;
            gap_cnt <= '0;
            tog_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sw_q <= level;
                    if (bus.btn_in != level) begin
                        sw_q <= bus.btn_in;
                        if (N_BOUNCES == 0) begin
                            level <= bus.btn_in;
                        end else begin
                            target  <= bus.btn_in;
                            tog_cnt <= T_LOAD;
                            gap_cnt <= next_gap;
                            state   <= BOUNCE;
                        end
                    end
                end
                BOUNCE: begin
                    if (gap_cnt == GAP_ONE) begin
                        sw_q    <= ~sw_q;
                        tog_cnt <= tog_cnt - T_ONE;
                        gap_cnt <= next_gap;
                        if (tog_cnt == T_ONE) begin
                            level <= target;
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sw_out = sw_q;
    assign bus.busy   = (state == BOUNCE);

endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen: one instance with N_BOUNCES=2/GAP_BITS=4 for
// burst behaviour and one with N_BOUNCES=0 for the pass-through case.
module tb_bounce_gen;

    logic clk;
    logic rst;

    bounce_if bus_a ();
    bounce_if bus_b ();

    bounce_gen #(.N_BOUNCES(2), .GAP_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    bounce_gen #(.N_BOUNCES(0), .GAP_BITS(4)) dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int total;
    int bad;

    int   w_trans;
    int   w_first;
    int   w_gap_bad;
    logic w_busy_first;
    logic w_busy_last;
    logic w_final;
    logic w_timeout;
    int   w_gaps [8];
    int   ref_gaps [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Follows one burst on instance A from the next edge until busy drops.
    task automatic watch_burst(input int flip_at, input logic flip_val);
        logic prev;
        int   cyc;
        int   last;
        bit   done;
        bit   flipped;
        prev = bus_a.sw_out;
        cyc = 0; last = 0; done = 0; flipped = 0;
        w_trans = 0; w_first = 0; w_gap_bad = 0;
        w_busy_first = 1'b0; w_busy_last = 1'b1;
        for (int i = 0; i < 8; i++) w_gaps[i] = 0;
        while (!done && cyc < 200) begin
            step();
            cyc++;
            if (bus_a.sw_out !== prev) begin
                w_trans++;
                if (w_trans == 1) begin
                    w_first = cyc;
                    w_busy_first = bus_a.busy;
                end else begin
                    if (w_trans - 2 < 8) w_gaps[w_trans-2] = cyc - last;
                    if ((cyc - last) < 1 || (cyc - last) > 16) w_gap_bad++;
                end
                last = cyc;
                prev = bus_a.sw_out;
                w_busy_last = bus_a.busy;
            end
            if (w_trans > 0 && bus_a.busy === 1'b0) done = 1;
            if (flip_at > 0 && w_trans == flip_at && !flipped) begin
                bus_a.btn_in = flip_val;
                flipped = 1;
            end
        end
        w_timeout = !done;
        w_final = bus_a.sw_out;
    endtask

    task automatic test_reset();
        bus_a.btn_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (bus_a.sw_out !== 1'b0) begin bad++; $display("[TB] FAIL rst_sw: got %b expected 0", bus_a.sw_out); end
            total++;
            if (bus_a.busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b expected 0", bus_a.busy); end
        end
        rst = 1'b0;
        watch_burst(0, 1'b0);
        total++;
        if (w_timeout !== 1'b0) begin bad++; $display("[TB] FAIL press_timeout: got %b expected 0", w_timeout); end
        total++;
        if (w_first !== 1) begin bad++; $display("[TB] FAIL press_latency: got %0d expected 1", w_first); end
        total++;
        if (w_busy_first !== 1'b1) begin bad++; $display("[TB] FAIL press_busy: got %b expected 1", w_busy_first); end
        total++;
        if (w_trans !== 5) begin bad++; $display("[TB] FAIL press_trans: got %0d expected 5", w_trans); end
        total++;
        if (w_gap_bad !== 0) begin bad++; $display("[TB] FAIL press_gaps: got %0d expected 0", w_gap_bad); end
        total++;
        if (w_busy_last !== 1'b0) begin bad++; $display("[TB] FAIL press_busy_fall: got %b expected 0", w_busy_last); end
        total++;
        if (w_final !== 1'b1) begin bad++; $display("[TB] FAIL press_final: got %b expected 1", w_final); end
        for (int i = 0; i < 8; i++) ref_gaps[i] = w_gaps[i];
    endtask

    task automatic test_release();
        bus_a.btn_in = 1'b0;
        watch_burst(0, 1'b0);
        total++;
        if (w_first !== 1) begin bad++; $display("[TB] FAIL rel_latency: got %0d expected 1", w_first); end
        total++;
        if (w_trans !== 5) begin bad++; $display("[TB] FAIL rel_trans: got %0d expected 5", w_trans); end
        total++;
        if (w_gap_bad !== 0) begin bad++; $display("[TB] FAIL rel_gaps: got %0d expected 0", w_gap_bad); end
        total++;
        if (w_final !== 1'b0) begin bad++; $display("[TB] FAIL rel_final: got %b expected 0", w_final); end
        total++;
        if (dut.level !== 1'b0) begin bad++; $display("[TB] FAIL rel_level: got %b expected 0", dut.level); end
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (bus_a.sw_out !== 1'b0 || bus_a.busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rel_settled: got sw=%b busy=%b expected sw=0 busy=0", bus_a.sw_out, bus_a.busy);
            end
        end
    endtask

    task automatic test_glitch();
        bus_a.btn_in = 1'b1;
        watch_burst(2, 1'b0);
        total++;
        if (w_trans !== 5) begin bad++; $display("[TB] FAIL glitch_trans: got %0d expected 5", w_trans); end
        total++;
        if (w_final !== 1'b1) begin bad++; $display("[TB] FAIL glitch_final: got %b expected 1", w_final); end
        step();
        total++;
        if (bus_a.sw_out !== 1'b0) begin bad++; $display("[TB] FAIL glitch_restart_sw: got %b expected 0", bus_a.sw_out); end
        total++;
        if (bus_a.busy !== 1'b1) begin bad++; $display("[TB] FAIL glitch_restart_busy: got %b expected 1", bus_a.busy); end
        watch_burst(0, 1'b0);
        total++;
        if (w_trans !== 4) begin bad++; $display("[TB] FAIL glitch_second_trans: got %0d expected 4", w_trans); end
        total++;
        if (w_final !== 1'b0) begin bad++; $display("[TB] FAIL glitch_second_final: got %b expected 0", w_final); end
    endtask

    task automatic test_reset_mid();
        int n;
        int cyc;
        logic prev;
        int seq_diff;
        bus_a.btn_in = 1'b1;
        prev = bus_a.sw_out;
        n = 0; cyc = 0;
        while (n < 3 && cyc < 60) begin
            step();
            cyc++;
            if (bus_a.sw_out !== prev) begin
                n++;
                prev = bus_a.sw_out;
            end
        end
        total++;
        if (n !== 3) begin bad++; $display("[TB] FAIL mid_reach: got %0d expected 3", n); end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (bus_a.sw_out !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_sw: got %b expected 0", bus_a.sw_out); end
        total++;
        if (bus_a.busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_busy: got %b expected 0", bus_a.busy); end
        total++;
        if (dut.lfsr !== 16'hACE1) begin bad++; $display("[TB] FAIL mid_rst_lfsr: got %h expected ace1", dut.lfsr); end
        step();
        rst = 1'b0;
        watch_burst(0, 1'b0);
        total++;
        if (w_first !== 1) begin bad++; $display("[TB] FAIL mid_latency: got %0d expected 1", w_first); end
        total++;
        if (w_trans !== 5) begin bad++; $display("[TB] FAIL mid_trans: got %0d expected 5", w_trans); end
        seq_diff = 0;
        for (int i = 0; i < 8; i++) if (w_gaps[i] != ref_gaps[i]) seq_diff++;
        total++;
        if (seq_diff !== 0) begin
            bad++;
            $display("[TB] FAIL mid_gap_seq: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     w_gaps[0], w_gaps[1], w_gaps[2], w_gaps[3],
                     ref_gaps[0], ref_gaps[1], ref_gaps[2], ref_gaps[3]);
        end
    endtask

    task automatic test_no_bounce();
        logic expv;
        for (int k = 0; k < 2; k++) begin
            expv = (k == 0) ? 1'b1 : 1'b0;
            bus_b.btn_in = expv;
            total++;
            if (bus_b.sw_out !== ~expv) begin bad++; $display("[TB] FAIL nb_latency: got %b expected %b", bus_b.sw_out, ~expv); end
            for (int i = 0; i < 5; i++) begin
                step();
                total++;
                if (bus_b.sw_out !== expv || bus_b.busy !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL nb_follow: got sw=%b busy=%b expected sw=%b busy=0", bus_b.sw_out, bus_b.busy, expv);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus_a.btn_in = 1'b0;
        bus_b.btn_in = 1'b0;
        test_reset();
        test_release();
        test_glitch();
        test_reset_mid();
        test_no_bounce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 The module SHALL have parameter N_BOUNCES, default 6, meaning extra toggle pairs emitted per level change.
REQ-002 The module SHALL have parameter GAP_BITS, default 8, meaning width of the pseudo-random gap between toggles (range 1..15).
REQ-003 The module SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-004 The module SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 The module SHALL have port btn_in, input, 1, clean requested switch level, synchronous to clk.
REQ-006 The module SHALL have port sw_out, output, 1, emulated mechanical switch output with contact bounce.
REQ-007 The module SHALL have port busy, output, 1, high while a bounce burst is in progress.

Function
REQ-008 The block SHALL be an FSM with states IDLE and BOUNCE; busy SHALL be 1 exactly when state is BOUNCE.
REQ-009 The block SHALL hold internal registers: level (settled output level), target (latched at burst start), gap counter (GAP_BITS+1 bits), toggle counter (wide enough for 2*N_BOUNCES), 16-bit LFSR.
REQ-010 The LFSR SHALL be Fibonacci, polynomial x^16+x^14+x^13+x^11+1, seed 0xACE1, advance every cycle including in IDLE, and never reach 0.
REQ-011 In IDLE with btn_in == level, sw_out SHALL equal level and nothing else changes except the LFSR.
REQ-012 In IDLE with btn_in != level at a rising edge: sw_out SHALL take btn_in at that edge (1-cycle latency), target SHALL latch btn_in, toggle counter SHALL load 2*N_BOUNCES, gap counter SHALL load G = LFSR[GAP_BITS-1:0] + 1, and state SHALL go to BOUNCE.
REQ-013 If N_BOUNCES = 0, REQ-012 SHALL instead update level and sw_out to btn_in and remain in IDLE; busy never asserts.
REQ-014 In BOUNCE the gap counter SHALL decrement each cycle; at the edge where it equals 1, sw_out SHALL invert, toggle counter SHALL decrement, and gap counter SHALL reload G from the current LFSR.
REQ-015 Consecutive sw_out transitions within a burst SHALL be separated by G cycles, 1 <= G <= 2^GAP_BITS.
REQ-016 When the toggle counter reaches 0 after a toggle, sw_out SHALL equal target, level SHALL load target, and state SHALL return to IDLE on that same edge.
REQ-017 A burst SHALL therefore produce exactly 1 + 2*N_BOUNCES transitions on sw_out, final value target.
REQ-018 btn_in changes during BOUNCE SHALL be ignored; on return to IDLE, if btn_in != level, a new burst SHALL start on the next edge per REQ-012.
REQ-019 Gap arithmetic SHALL be unsigned, GAP_BITS+1 wide, so G = 2^GAP_BITS does not overflow.

Reset
REQ-020 While rst is high, state SHALL be IDLE, sw_out = 0, level = 0, target = 0, busy = 0, counters = 0, LFSR = 0xACE1, asynchronously.
REQ-021 Assertion of rst mid-burst SHALL abort the burst immediately; after release the block SHALL behave as freshly reset (btn_in = 1 then starts a new burst).
REQ-022 The first rising edge after rst deasserts SHALL be an ordinary operating edge.

Verification
REQ-023 Reset: rst=1 with btn_in=1 -> sw_out=0, busy=0 throughout; release -> sw_out=1 one edge later, busy=1.
REQ-024 Press, N_BOUNCES=2, GAP_BITS=4: btn_in 0->1 held -> exactly 5 sw_out transitions, every gap in 1..16 cycles, final sw_out=1, busy falls on the final toggle edge.
REQ-025 Release after settle: btn_in 1->0 -> sw_out goes 0 next edge, 2*N_BOUNCES further toggles, settles 0, level=0.
REQ-026 Glitch during burst: btn_in 0->1, then back to 0 for 3 cycles mid-burst -> burst completes at 1, then a new burst to 0 starts on the next edge.
REQ-027 Reset mid-burst: rst pulse after 2nd toggle -> sw_out=0, busy=0 immediately; LFSR restarts at 0xACE1, so a repeated press reproduces the identical gap sequence as after the first reset.
REQ-028 N_BOUNCES=0: btn_in toggles 0->1->0 at 5-cycle spacing -> sw_out mirrors btn_in with 1-cycle latency, busy stays 0.
